// File: rtl/pwm_pkg.sv
// Shared PWM definitions: duty width, duty type and the default safe duty window.
package pwm_pkg;

    localparam int unsigned DUTY_W = 7;

    typedef logic [DUTY_W-1:0] duty_t;

    localparam duty_t DUTY_MIN   = 7'd2;
    localparam duty_t DUTY_MAX   = 7'd97;
    localparam duty_t RESET_DUTY = 7'd50;
    localparam duty_t MAX_STEP   = 7'd4;

endpackage

// File: rtl/duty_slew_channel.sv
// One duty leg: clamps a request into a pending register, loads it as the target on a tick, slews the output.
// Latency: output moves one cycle after a tick. Backpressure: none here; the parent gates accept_i.
// Disable forces target and output to the reset duty on the next edge.
module duty_slew_channel
    import pwm_pkg::*;
#(
    parameter int unsigned              DutyWidth = DUTY_W,
    parameter logic [DutyWidth-1:0]     DutyMin   = DUTY_MIN,
    parameter logic [DutyWidth-1:0]     DutyMax   = DUTY_MAX,
    parameter logic [DutyWidth-1:0]     MaxStep   = MAX_STEP,
    parameter logic [DutyWidth-1:0]     ResetDuty = RESET_DUTY
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 accept_i,
    input  logic                 tick_i,
    input  logic                 load_i,
    input  logic [DutyWidth-1:0] req_i,
    output logic [DutyWidth-1:0] duty_o,
    output logic                 clamped_o,
    output logic                 ramping_o
);

    localparam logic signed [DutyWidth:0] StepS = $signed({1'b0, MaxStep});

    logic [DutyWidth-1:0]        pending_q, pending_d;
    logic [DutyWidth-1:0]        target_q, target_d;
    logic [DutyWidth-1:0]        duty_q, duty_d;
    logic [DutyWidth-1:0]        req_clamped;
    logic [DutyWidth-1:0]        eff_target;
    logic signed [DutyWidth:0]   diff;

    always_comb begin
        req_clamped = req_i;
        if (req_i < DutyMin) begin
            req_clamped = DutyMin;
        end else if (req_i > DutyMax) begin
            req_clamped = DutyMax;
        end
        clamped_o = (req_clamped != req_i);

        // A tick that loads the pending value steps toward it in the same update.
        eff_target = load_i ? pending_q : target_q;
        diff       = $signed({1'b0, eff_target}) - $signed({1'b0, duty_q});

        pending_d = accept_i ? req_clamped : pending_q;
        target_d  = target_q;
        duty_d    = duty_q;

        if (!enable_i) begin
            target_d = ResetDuty;
            duty_d   = ResetDuty;
        end else if (tick_i) begin
            target_d = eff_target;
            if (diff > StepS) begin
                duty_d = duty_q + MaxStep;
            end else if (diff < -StepS) begin
                duty_d = duty_q - MaxStep;
            end else begin
                duty_d = eff_target;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= ResetDuty;
            target_q  <= ResetDuty;
            duty_q    <= ResetDuty;
        end else begin
            pending_q <= pending_d;
            target_q  <= target_d;
            duty_q    <= duty_d;
        end
    end

    assign duty_o    = duty_q;
    assign ramping_o = (duty_q != target_q);

endmodule

// File: rtl/duty_update_ctrl.sv
// Accepts clamped duty requests for two PWM legs and applies them slew-limited on carrier update ticks.
// Latency: request accepted before tick M reaches the outputs at M+1. Backpressure: single pending slot,
// ready is registered and low while the slot is full or the converter is disabled.
module duty_update_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned              DutyWidth = DUTY_W,
    parameter logic [DutyWidth-1:0]     DutyMin   = DUTY_MIN,
    parameter logic [DutyWidth-1:0]     DutyMax   = DUTY_MAX,
    parameter logic [DutyWidth-1:0]     MaxStep   = MAX_STEP,
    parameter logic [DutyWidth-1:0]     ResetDuty = RESET_DUTY
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 update_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [DutyWidth-1:0] req_d1_i,
    input  logic [DutyWidth-1:0] req_d2_i,
    output logic [DutyWidth-1:0] duty_d1_o,
    output logic [DutyWidth-1:0] duty_d2_o,
    output logic                 ramping_o,
    output logic                 clamp_o
);

    logic pending_valid_q, pending_valid_d;
    logic req_ready_q, req_ready_d;
    logic clamp_q, clamp_d;
    logic accept, tick, load;
    logic clamped_d1, clamped_d2;
    logic ramping_d1, ramping_d2;

    assign accept = req_valid_i & req_ready_q;
    assign tick   = update_i & enable_i;
    // Accept needs an empty slot and load needs a full one, so they never coincide.
    assign load   = tick & pending_valid_q;

    always_comb begin
        pending_valid_d = pending_valid_q;
        clamp_d         = clamp_q;
        if (!enable_i) begin
            pending_valid_d = 1'b0;
        end else if (accept) begin
            pending_valid_d = 1'b1;
            clamp_d         = clamped_d1 | clamped_d2;
        end else if (load) begin
            pending_valid_d = 1'b0;
        end
        req_ready_d = enable_i & ~pending_valid_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_valid_q <= 1'b0;
            req_ready_q     <= 1'b0;
            clamp_q         <= 1'b0;
        end else begin
            pending_valid_q <= pending_valid_d;
            req_ready_q     <= req_ready_d;
            clamp_q         <= clamp_d;
        end
    end

    duty_slew_channel #(
        .DutyWidth (DutyWidth),
        .DutyMin   (DutyMin),
        .DutyMax   (DutyMax),
        .MaxStep   (MaxStep),
        .ResetDuty (ResetDuty)
    ) u_leg1 (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .enable_i  (enable_i),
        .accept_i  (accept),
        .tick_i    (tick),
        .load_i    (load),
        .req_i     (req_d1_i),
        .duty_o    (duty_d1_o),
        .clamped_o (clamped_d1),
        .ramping_o (ramping_d1)
    );

    duty_slew_channel #(
        .DutyWidth (DutyWidth),
        .DutyMin   (DutyMin),
        .DutyMax   (DutyMax),
        .MaxStep   (MaxStep),
        .ResetDuty (ResetDuty)
    ) u_leg2 (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .enable_i  (enable_i),
        .accept_i  (accept),
        .tick_i    (tick),
        .load_i    (load),
        .req_i     (req_d2_i),
        .duty_o    (duty_d2_o),
        .clamped_o (clamped_d2),
        .ramping_o (ramping_d2)
    );

    assign req_ready_o = req_ready_q;
    assign ramping_o   = ramping_d1 | ramping_d2;
    assign clamp_o     = clamp_q;

endmodule

// File: tb/tb_duty_update_ctrl.sv
// Directed bench for duty_update_ctrl: reset, ramps, clamping, tick/accept overlap, disable and async reset.
module tb_duty_update_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       update;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_d1;
    logic [6:0] req_d2;
    logic [6:0] duty_d1;
    logic [6:0] duty_d2;
    logic       ramping;
    logic       clamp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    duty_update_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (enable),
        .update_i    (update),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_d1_i    (req_d1),
        .req_d2_i    (req_d2),
        .duty_d1_o   (duty_d1),
        .duty_d2_o   (duty_d2),
        .ramping_o   (ramping),
        .clamp_o     (clamp)
    );

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        update = 1'b1;
        clk_step();
        update = 1'b0;
    endtask

    task automatic send_req(input logic [6:0] a, input logic [6:0] b);
        int waited = 0;
        while (req_ready !== 1'b1 && waited < 20) begin
            clk_step();
            waited++;
        end
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL send_ready_timeout: ready=%b want 1", req_ready);
        end
        n_cmp++;
        req_valid = 1'b1;
        req_d1    = a;
        req_d2    = b;
        clk_step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; update = 1'b0; req_valid = 1'b0;
        req_d1 = 7'd0; req_d2 = 7'd0;
        #12;
        if (duty_d1 !== 7'd50) begin n_err++; $display("FAIL reset_d1: got %0d want 50", duty_d1); end
        n_cmp++;
        if (duty_d2 !== 7'd50) begin n_err++; $display("FAIL reset_d2: got %0d want 50", duty_d2); end
        n_cmp++;
        if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        n_cmp++;
        if (ramping !== 1'b0 || clamp !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: ramp=%b clamp=%b want 0 0", ramping, clamp);
        end
        n_cmp++;
        #10 rst_n = 1'b1;
        clk_step();
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready: got %b want 1", req_ready); end
        n_cmp++;
        for (int k = 0; k < 2; k++) begin
            repeat (4) clk_step();
            do_tick();
            if (duty_d1 !== 7'd50 || duty_d2 !== 7'd50 || ramping !== 1'b0) begin
                n_err++;
                $display("FAIL idle_tick: d1=%0d d2=%0d ramp=%b want 50 50 0", duty_d1, duty_d2, ramping);
            end
            n_cmp++;
        end
    endtask

    task automatic test_ramp();
        logic [6:0] e1, e2;
        send_req(7'd70, 7'd30);
        if (req_ready !== 1'b0 || clamp !== 1'b0) begin
            n_err++; $display("FAIL ramp_accept: ready=%b clamp=%b want 0 0", req_ready, clamp);
        end
        n_cmp++;
        repeat (3) clk_step();
        if (duty_d1 !== 7'd50 || duty_d2 !== 7'd50) begin
            n_err++; $display("FAIL ramp_pre_tick: d1=%0d d2=%0d want 50 50", duty_d1, duty_d2);
        end
        n_cmp++;
        for (int k = 1; k <= 5; k++) begin
            do_tick();
            e1 = 7'(50 + 4 * k);
            e2 = 7'(50 - 4 * k);
            if (duty_d1 !== e1 || duty_d2 !== e2) begin
                n_err++; $display("FAIL ramp_step%0d: d1=%0d d2=%0d want %0d %0d", k, duty_d1, duty_d2, e1, e2);
            end
            n_cmp++;
            if (ramping !== (k < 5)) begin
                n_err++; $display("FAIL ramp_flag%0d: got %b want %b", k, ramping, (k < 5));
            end
            n_cmp++;
            repeat (2) clk_step();
            if (duty_d1 !== e1 || duty_d2 !== e2) begin
                n_err++; $display("FAIL ramp_hold%0d: d1=%0d d2=%0d want %0d %0d", k, duty_d1, duty_d2, e1, e2);
            end
            n_cmp++;
        end
    endtask

    task automatic test_clamp();
        logic [6:0] e1_tab [7] = '{7'd74, 7'd78, 7'd82, 7'd86, 7'd90, 7'd94, 7'd97};
        logic [6:0] e2_tab [7] = '{7'd26, 7'd22, 7'd18, 7'd14, 7'd10, 7'd6, 7'd2};
        send_req(7'd120, 7'd0);
        if (clamp !== 1'b1) begin n_err++; $display("FAIL clamp_flag: got %b want 1", clamp); end
        n_cmp++;
        for (int k = 0; k < 7; k++) begin
            do_tick();
            if (duty_d1 !== e1_tab[k] || duty_d2 !== e2_tab[k]) begin
                n_err++;
                $display("FAIL clamp_step%0d: d1=%0d d2=%0d want %0d %0d", k, duty_d1, duty_d2, e1_tab[k], e2_tab[k]);
            end
            n_cmp++;
        end
        do_tick();
        if (duty_d1 !== 7'd97 || duty_d2 !== 7'd2 || ramping !== 1'b0) begin
            n_err++; $display("FAIL clamp_settle: d1=%0d d2=%0d ramp=%b want 97 2 0", duty_d1, duty_d2, ramping);
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        send_req(7'd80, 7'd20);
        if (clamp !== 1'b0) begin n_err++; $display("FAIL b2b_clamp: got %b want 0", clamp); end
        n_cmp++;
        do_tick();
        if (duty_d1 !== 7'd93 || duty_d2 !== 7'd6) begin
            n_err++; $display("FAIL b2b_first: d1=%0d d2=%0d want 93 6", duty_d1, duty_d2);
        end
        n_cmp++;
        // Request and tick on the same edge: tick uses the old target.
        req_valid = 1'b1; req_d1 = 7'd90; req_d2 = 7'd10; update = 1'b1;
        clk_step();
        update = 1'b0;
        req_d1 = 7'd40; req_d2 = 7'd60;
        if (duty_d1 !== 7'd89 || duty_d2 !== 7'd10 || req_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_overlap: d1=%0d d2=%0d ready=%b want 89 10 0", duty_d1, duty_d2, req_ready);
        end
        n_cmp++;
        clk_step();
        if (req_ready !== 1'b0 || duty_d1 !== 7'd89) begin
            n_err++; $display("FAIL b2b_full: ready=%b d1=%0d want 0 89", req_ready, duty_d1);
        end
        n_cmp++;
        do_tick();
        if (duty_d1 !== 7'd90 || duty_d2 !== 7'd10 || ramping !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_load: d1=%0d d2=%0d ramp=%b ready=%b want 90 10 0 1", duty_d1, duty_d2, ramping, req_ready);
        end
        n_cmp++;
        clk_step();
        req_valid = 1'b0;
        if (req_ready !== 1'b0 || duty_d1 !== 7'd90) begin
            n_err++; $display("FAIL b2b_second_accept: ready=%b d1=%0d want 0 90", req_ready, duty_d1);
        end
        n_cmp++;
        do_tick();
        if (duty_d1 !== 7'd86 || duty_d2 !== 7'd14 || ramping !== 1'b1) begin
            n_err++; $display("FAIL b2b_second_step: d1=%0d d2=%0d ramp=%b want 86 14 1", duty_d1, duty_d2, ramping);
        end
        n_cmp++;
    endtask

    task automatic test_disable();
        send_req(7'd120, 7'd70);
        if (clamp !== 1'b1 || req_ready !== 1'b0) begin
            n_err++; $display("FAIL dis_setup: clamp=%b ready=%b want 1 0", clamp, req_ready);
        end
        n_cmp++;
        enable = 1'b0;
        clk_step();
        if (duty_d1 !== 7'd50 || duty_d2 !== 7'd50 || req_ready !== 1'b0 || ramping !== 1'b0) begin
            n_err++;
            $display("FAIL dis_force: d1=%0d d2=%0d ready=%b ramp=%b want 50 50 0 0", duty_d1, duty_d2, req_ready, ramping);
        end
        n_cmp++;
        if (clamp !== 1'b1) begin n_err++; $display("FAIL dis_clamp_kept: got %b want 1", clamp); end
        n_cmp++;
        do_tick();
        if (duty_d1 !== 7'd50 || duty_d2 !== 7'd50) begin
            n_err++; $display("FAIL dis_tick_ignored: d1=%0d d2=%0d want 50 50", duty_d1, duty_d2);
        end
        n_cmp++;
        enable = 1'b1;
        clk_step();
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL reen_ready: got %b want 1", req_ready); end
        n_cmp++;
        do_tick();
        if (duty_d1 !== 7'd50 || duty_d2 !== 7'd50) begin
            n_err++; $display("FAIL reen_pending_cleared: d1=%0d d2=%0d want 50 50", duty_d1, duty_d2);
        end
        n_cmp++;
        send_req(7'd0, 7'd38);
        do_tick();
        if (duty_d1 !== 7'd46 || duty_d2 !== 7'd46 || clamp !== 1'b1 || ramping !== 1'b1) begin
            n_err++;
            $display("FAIL reen_ramp: d1=%0d d2=%0d clamp=%b ramp=%b want 46 46 1 1", duty_d1, duty_d2, clamp, ramping);
        end
        n_cmp++;
    endtask

    task automatic test_async_reset();
        #3 rst_n = 1'b0;
        #1;
        if (duty_d1 !== 7'd50 || duty_d2 !== 7'd50) begin
            n_err++; $display("FAIL arst_duty: d1=%0d d2=%0d want 50 50", duty_d1, duty_d2);
        end
        n_cmp++;
        if (ramping !== 1'b0 || clamp !== 1'b0 || req_ready !== 1'b0) begin
            n_err++; $display("FAIL arst_flags: ramp=%b clamp=%b ready=%b want 0 0 0", ramping, clamp, req_ready);
        end
        n_cmp++;
        #2 rst_n = 1'b1;
        clk_step();
        if (req_ready !== 1'b1 || duty_d1 !== 7'd50) begin
            n_err++; $display("FAIL arst_release: ready=%b d1=%0d want 1 50", req_ready, duty_d1);
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_clamp();
        test_back_to_back();
        test_disable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/duty_update_ctrl.md
Name: duty_update_ctrl

Overview:
- Sits directly upstream of the phase-shifted PWM stage. Takes duty-cycle requests for both legs from the control loop through a valid/ready handshake, and clamps them to a safe window.
- Applies each request only on the carrier-synchronous update tick, using the PWM's ADC trigger.
- Slew-limits each leg so its duty changes by at most MaxStep counts per carrier period.
- Drives the PWM stage's duty_d1_i / duty_d2_i inputs directly from registers.

Parameters:
- DutyWidth, 7, width of all duty values; matches the 7-bit carrier.
- DutyMin, 7'd2, lowest duty presented to the PWM; keeps pulses longer than the dead time.
- DutyMax, 7'd97, highest duty presented to the PWM.
- MaxStep, 7'd4, maximum change per channel per update tick; 0 is illegal.
- ResetDuty, 7'd50, duty value after reset and while disabled; must satisfy DutyMin <= ResetDuty <= DutyMax.

Ports:
- clk_i  in  1  system clock; all logic is on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- enable_i  in  1  converter enable; low forces the safe duty.
- update_i  in  1  one-cycle carrier-synchronous tick, connected to the PWM's adc_trigger_o.
- req_valid_i  in  1  a duty request is presented.
- req_ready_o  out  1  the block can accept a request.
- req_d1_i  in  DutyWidth  requested duty, leg 1.
- req_d2_i  in  DutyWidth  requested duty, leg 2.
- duty_d1_o  out  DutyWidth  registered duty to the PWM, leg 1.
- duty_d2_o  out  DutyWidth  registered duty to the PWM, leg 2.
- ramping_o  out  1  high while either output differs from its target.
- clamp_o  out  1  the last accepted request had at least one channel clamped.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - duty_d1_o, duty_d2_o, target_d1 and target_d2 all equal ResetDuty.
  - pending_valid=0, clamp_o=0, ramping_o=0, req_ready_o=0.
- Ready:
  - req_ready_o = enable_i & ~pending_valid, driven from registers only.
  - There is one pending slot.
- Accept:
  - A request is accepted on a cycle where req_valid_i & req_ready_o.
  - Each channel is stored in the pending slot as min(max(req, DutyMin), DutyMax).
  - pending_valid is set.
  - clamp_o is set to 1 if either channel was altered by the clamp, otherwise 0. It holds until the next acceptance.
- Update tick (update_i=1 and enable_i=1):
  - If pending_valid: target <= pending, and pending_valid is cleared.
  - Each output then moves toward the effective target, which is the pending value if loaded this tick, otherwise the current target. It moves by min(|target - duty|, MaxStep).
  - The difference is computed in DutyWidth+1 bits, signed.
  - The output never overshoots the target.
- Latency:
  - Request accepted at cycle N, first update tick at cycle M > N: outputs change at M+1.
  - No output changes on a non-tick cycle.
- Simultaneous accept and tick (possible only with pending_valid=0):
  - The tick acts on the old state: no pending data, so outputs keep stepping toward the old target.
  - The new request lands in the pending slot and is applied on the next tick.
- Request held while pending is full: req_ready_o=0, so the request is not accepted. The requester holds its data (standard valid/ready; no drop, no overwrite).
- Disable (enable_i=0), on the next clock edge:
  - duty outputs and targets go to ResetDuty.
  - pending_valid is cleared; req_ready_o=0.
  - update_i is ignored.
  - clamp_o is retained.
- Re-enable: starts from ResetDuty. The first accepted request ramps from there.
- ramping_o = (duty_d1_o != target_d1) | (duty_d2_o != target_d2), derived from registers.
- The two channels are fully independent in stepping; one can settle while the other ramps.

Decomposition:
- Shared package pwm_pkg holds:
  - DUTY_W = 7 and typedef duty_t = logic [DUTY_W-1:0].
  - Default DUTY_MIN, DUTY_MAX, RESET_DUTY and MAX_STEP constants, reused by the PWM top-level.
- Sub-module duty_slew_channel, instantiated twice. Per channel it contains the clamp, the pending register, the target register and the stepped output register.
- The top level holds the handshake, the pending_valid flag, the enable handling, clamp_o and ramping_o.

Test Plan:
- Reset release, enable=1, no requests, ticks every 128 cycles -> outputs stay 50, ready=1, ramping_o=0.
- Request (70,30) accepted, then ticks -> d1 steps 54,58,62,66,70 and d2 steps 46,42,38,34,30, each change at tick+1. ramping_o drops after the 5th tick. clamp_o=0.
- Request (120,0) -> pending holds (97,2), clamp_o=1. Outputs ramp by 4 per tick to 97 and 2 with no overshoot.
- Request accepted in the same cycle as a tick, with no pending -> outputs unchanged on that tick. New values start ramping on the following tick. A second valid while pending is full sees ready=0 and is accepted only after the next tick.
- Mid-ramp enable_i=0 -> both outputs are 50 on the next edge, pending cleared, ready=0, ticks ignored. Re-enable -> ready=1 and the ramp restarts from 50.
- Asynchronous rst_ni assertion mid-ramp, between clock edges -> outputs are immediately 50, ramping_o=0, clamp_o=0.
